// File: rtl/beep_pkg.sv
// Shared types and helpers for the beeper scheduler.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } beep_state_e;

    localparam int unsigned BEEP_CNT_W = 3;

    // Counter width able to hold 0..max_val-1, never narrower than one bit.
    function automatic int unsigned beep_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator with registered, mutable output.
module beep_tone_gen
    import beep_pkg::*;
#(
    parameter int unsigned TONE_DIV  = 16666,
    parameter int unsigned TONE_DUTY = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic restart,
    input  logic mute,
    output logic beep
);

    localparam int unsigned TW  = beep_width(TONE_DIV + 1);
    localparam int unsigned THR = TONE_DIV / TONE_DUTY;

    logic [TW-1:0] tone_cnt;

    // Tone counter runs only while enabled; output lags the counter by one cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tone_cnt <= '0;
            beep     <= 1'b0;
        end else begin
            beep <= en && (tone_cnt <= TW'(THR)) && !mute;
            if (!en || restart) begin
                tone_cnt <= '0;
            end else if (tone_cnt == TW'(TONE_DIV)) begin
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/beep_sched.sv
// Fixed-priority, non-preemptive scheduler sharing one beeper among alarm sources.
module beep_sched
    import beep_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned CNT_W     = BEEP_CNT_W,
    parameter int unsigned TONE_DIV  = 16666,
    parameter int unsigned TONE_DUTY = 8,
    parameter int unsigned ON_CYC    = 10_000_000,
    parameter int unsigned OFF_CYC   = 5_000_000,
    parameter int unsigned GAP_CYC   = 25_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   req_cnt,
    input  logic                     mute,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [N_REQ-1:0]         pend,
    output logic                     beep
);

    localparam int unsigned PH_MAX = (ON_CYC > OFF_CYC)
                                   ? ((ON_CYC  > GAP_CYC) ? ON_CYC  : GAP_CYC)
                                   : ((OFF_CYC > GAP_CYC) ? OFF_CYC : GAP_CYC);
    localparam int unsigned PH_W   = beep_width(PH_MAX);
    localparam int unsigned IDX_W  = beep_width(N_REQ);

    beep_state_e        state;
    logic [PH_W-1:0]    phase_cnt;
    logic [CNT_W-1:0]   beeps_left;
    logic [CNT_W-1:0]   cnt [N_REQ];
    logic [N_REQ-1:0]   pend_low;
    logic [N_REQ-1:0]   pend_clr;
    logic [IDX_W-1:0]   pick_idx;
    logic               phase_last;
    logic               tone_en;
    logic               tone_restart;

    // Lowest set pending bit wins arbitration.
    always_comb begin
        pend_low = pend & (~pend + N_REQ'(1));
        pick_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (pend[i]) pick_idx = IDX_W'(i);
        end
    end

    // Last cycle of the current timed phase.
    always_comb begin
        phase_last = 1'b0;
        case (state)
            ST_ON:   phase_last = (phase_cnt == PH_W'(ON_CYC - 1));
            ST_OFF:  phase_last = (phase_cnt == PH_W'(OFF_CYC - 1));
            ST_GAP:  phase_last = (phase_cnt == PH_W'(GAP_CYC - 1));
            default: phase_last = 1'b0;
        endcase
    end

    assign pend_clr     = (state == ST_IDLE) ? pend_low : '0;
    assign busy         = (state != ST_IDLE);
    assign tone_en      = (state == ST_ON);
    assign tone_restart = ((state == ST_IDLE) && (|pend)) || ((state == ST_OFF) && phase_last);

    // Pending bank plus sequencing FSM; a new request beats the clear on the grant edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            pend       <= '0;
            beeps_left <= '0;
            phase_cnt  <= '0;
            for (int i = 0; i < int'(N_REQ); i++) cnt[i] <= '0;
        end else begin
            grant <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req[i] && (!pend[i] || pend_clr[i])) begin
                    pend[i] <= 1'b1;
                    cnt[i]  <= (req_cnt[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                                  : req_cnt[i*CNT_W +: CNT_W];
                end else if (pend_clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        state      <= ST_ON;
                        grant      <= pend_low;
                        beeps_left <= cnt[pick_idx];
                        phase_cnt  <= '0;
                    end
                end
                ST_ON: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        if (beeps_left == CNT_W'(1)) begin
                            state <= ST_GAP;
                        end else begin
                            beeps_left <= beeps_left - CNT_W'(1);
                            state      <= ST_OFF;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                ST_OFF: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        state     <= ST_ON;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    beep_tone_gen #(
        .TONE_DIV  (TONE_DIV),
        .TONE_DUTY (TONE_DUTY)
    ) u_tone (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (tone_en),
        .restart   (tone_restart),
        .mute      (mute),
        .beep      (beep)
    );

endmodule

// File: tb/tb_beep_sched.sv
// Self-checking bench for beep_sched against a sequence-level reference model.
module tb_beep_sched;

    localparam int NR   = 4;
    localparam int CW   = 3;
    localparam int DIV  = 9;
    localparam int DUTY = 2;
    localparam int ON   = 20;
    localparam int OFF  = 10;
    localparam int GAP  = 5;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  req_cnt;
    logic              mute;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [NR-1:0]     pend;
    logic              beep;

    beep_sched #(
        .N_REQ(NR), .CNT_W(CW), .TONE_DIV(DIV), .TONE_DUTY(DUTY),
        .ON_CYC(ON), .OFF_CYC(OFF), .GAP_CYC(GAP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .req_cnt   (req_cnt),
        .mute      (mute),
        .grant     (grant),
        .busy      (busy),
        .pend      (pend),
        .beep      (beep)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one active sequence described by its grant edge and length.
    bit [NR-1:0] m_pend, m_grant;
    bit          m_busy, m_beep, m_act;
    int          m_cnt [NR];
    int          m_g, m_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int seq_len(input int n);
        return n * ON + (n - 1) * OFF + GAP;
    endfunction

    // Raw tone level at offset o of a sequence: inside a burst and in the high part of a period.
    function automatic bit tone_at(input int o, input int len);
        int ph;
        if (o < 0 || o >= len - GAP) return 1'b0;
        ph = o % (ON + OFF);
        if (ph >= ON) return 1'b0;
        return (ph % (DIV + 1)) <= (DIV / DUTY);
    endfunction

    task automatic model_edge();
        int          o_prev;
        bit          idle_prev;
        bit [NR-1:0] clr;
        int          k;
        int          c;
        cyc++;
        if (!sys_rst_n) begin
            m_pend = '0; m_grant = '0; m_busy = 1'b0; m_beep = 1'b0; m_act = 1'b0;
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else begin
            o_prev    = cyc - 1 - m_g;
            idle_prev = !m_act || (o_prev >= m_len);
            m_beep    = m_act && tone_at(o_prev, m_len) && !mute;
            clr       = '0;
            m_grant   = '0;
            if (idle_prev && (m_pend != 0)) begin
                k = 0;
                for (int i = NR - 1; i >= 0; i--) if (m_pend[i]) k = i;
                clr[k]     = 1'b1;
                m_grant[k] = 1'b1;
                m_act      = 1'b1;
                m_g        = cyc;
                m_len      = seq_len(m_cnt[k]);
            end
            for (int i = 0; i < NR; i++) begin
                if (req[i] && (!m_pend[i] || clr[i])) begin
                    m_pend[i] = 1'b1;
                    c = int'(req_cnt[i*CW +: CW]);
                    m_cnt[i] = (c == 0) ? 1 : c;
                end else if (clr[i]) begin
                    m_pend[i] = 1'b0;
                end
            end
            m_busy = m_act && ((cyc - m_g) < m_len);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        #1;
        check("grant", 32'(grant), 32'(m_grant));
        check("busy",  32'(busy),  32'(m_busy));
        check("pend",  32'(pend),  32'(m_pend));
        check("beep",  32'(beep),  32'(m_beep));
    endtask

    task automatic set_req(input int idx, input int c);
        req[idx] = 1'b1;
        req_cnt[idx*CW +: CW] = CW'(c);
    endtask

    task automatic wait_grant(output logic [NR-1:0] g, output int at);
        bit done = 1'b0;
        g  = '0;
        at = -1;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            if (grant != '0) begin
                g    = grant;
                at   = cyc;
                done = 1'b1;
            end
        end
        check("grant_seen", 32'(done), 32'd1);
    endtask

    task automatic measure_busy(output int blen, output int bhi);
        bit done = 1'b0;
        blen = 1;
        bhi  = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            tick();
            if (busy !== 1'b1) done = 1'b1;
            else begin
                blen++;
                if (beep === 1'b1) bhi++;
            end
        end
    endtask

    task automatic idle_wait();
        for (int n = 0; n < 600 && (busy !== 1'b0 || pend !== '0); n++) tick();
        check("idle_reached", 32'(busy | (|pend)), 32'd0);
    endtask

    task automatic count_grants(input int n, output int ng);
        ng = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (grant != '0) ng++;
        end
    endtask

    logic [NR-1:0] g;
    int a1, a2, blen, bhi, ng;

    initial begin
        sys_rst_n = 1'b0;
        req       = '0;
        req_cnt   = '0;
        mute      = 1'b0;
        m_g       = 0;
        m_len     = 0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();

        // Single source, count 3.
        set_req(2, 3); tick(); req = '0;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        measure_busy(blen, bhi);
        check("single_len", 32'(blen), 32'd85);
        check("single_hi",  32'(bhi),  32'd30);
        idle_wait();

        // Priority between simultaneous requests.
        set_req(3, 1); set_req(1, 2); tick(); req = '0;
        wait_grant(g, a1);
        check("prio_first", 32'(g), 32'h2);
        wait_grant(g, a2);
        check("prio_second", 32'(g), 32'h8);
        check("prio_gap", 32'(a2 - a1), 32'd56);
        idle_wait();

        // Non-preemption and duplicate request.
        set_req(3, 1); tick(); req = '0;
        wait_grant(g, a1);
        check("np_first", 32'(g), 32'h8);
        repeat (5) tick();
        set_req(0, 2); set_req(3, 1); tick(); req = '0;
        repeat (3) tick();
        set_req(3, 5); tick(); req = '0;
        check("dup_pend", 32'(pend), 32'h9);
        wait_grant(g, a1);
        check("np_hi", 32'(g), 32'h1);
        wait_grant(g, a1);
        check("np_again", 32'(g), 32'h8);
        measure_busy(blen, bhi);
        check("dup_len", 32'(blen), 32'd25);
        count_grants(40, ng);
        check("dup_once", 32'(ng), 32'd0);
        idle_wait();

        // Count zero means one burst.
        set_req(2, 0); tick(); req = '0;
        wait_grant(g, a1);
        measure_busy(blen, bhi);
        check("zero_len", 32'(blen), 32'd25);
        check("zero_hi",  32'(bhi),  32'd10);
        idle_wait();

        // Mute silences the pin but not the sequencing.
        mute = 1'b1;
        set_req(1, 2); tick(); req = '0;
        wait_grant(g, a1);
        check("mute_grant", 32'(g), 32'h2);
        measure_busy(blen, bhi);
        check("mute_len", 32'(blen), 32'd55);
        check("mute_hi",  32'(bhi),  32'd0);
        mute = 1'b0;
        idle_wait();

        // Reset during OFF with requests pending.
        set_req(0, 2); tick(); req = '0;
        wait_grant(g, a1);
        repeat (22) tick();
        set_req(1, 3); set_req(3, 2); tick(); req = '0;
        tick();
        check("rst_pre_pend", 32'(pend), 32'ha);
        sys_rst_n = 1'b0;
        tick();
        check("rst_pend",  32'(pend),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_beep",  32'(beep),  32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        sys_rst_n = 1'b1;
        count_grants(40, ng);
        check("rst_no_grant", 32'(ng), 32'd0);

        // Re-request on the grant edge.
        set_req(2, 1); tick();
        set_req(2, 2); tick(); req = '0;
        check("same_grant", 32'(grant), 32'h4);
        check("same_pend",  32'(pend[2]), 32'd1);
        measure_busy(blen, bhi);
        check("same_len1", 32'(blen), 32'd25);
        wait_grant(g, a1);
        check("same_grant2", 32'(g), 32'h4);
        measure_busy(blen, bhi);
        check("same_len2", 32'(blen), 32'd55);
        idle_wait();

        // Randomized traffic, mute toggling and rare resets.
        for (int c = 0; c < 4000; c++) begin
            req = '0;
            for (int i = 0; i < NR; i++) if ($urandom_range(0, 59) == 0) req[i] = 1'b1;
            req_cnt = (NR*CW)'($urandom);
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            sys_rst_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        req = '0;
        mute = 1'b0;
        sys_rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
